// File: rtl/spi_word_port.sv
// spi_word_port
// Word-wide access adapter in front of a byte-wide SPI RAM controller.
// A 16-bit read or write request is split into two byte transactions
// (address A, then A+1) on the controller's start/busy handshake. Read bytes
// are reassembled little-endian: byte at A -> [7:0], byte at A+1 -> [15:8].
//
// Optional feature macro: SPI_WORD_PREFETCH_EN
//   When defined, every completed read is followed by a speculative fetch of
//   the next sequential word (A+2) into a one-word buffer. A later read that
//   hits the buffer completes one cycle after acceptance. Any write
//   invalidates the buffer.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   req_addr/req_read/req_write/req_wdata   CPU request, sampled when ready=1
//   ready               idle and accepting a request
//   rsp_valid           one-cycle completion pulse
//   rsp_rdata           last read word, held until the next read completes
//   ram_addr/ram_wdata  registered byte address / write byte to controller
//   ram_start_read/ram_start_write  one-cycle start pulses
//   ram_rdata/ram_busy  controller read byte and busy flag
module spi_word_port #(
  parameter int ADDR_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic                 req_read,
  input  logic                 req_write,
  input  logic [15:0]          req_wdata,
  output logic                 ready,
  output logic                 rsp_valid,
  output logic [15:0]          rsp_rdata,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [7:0]           ram_wdata,
  output logic                 ram_start_read,
  output logic                 ram_start_write,
  input  logic [7:0]           ram_rdata,
  input  logic                 ram_busy
);

  typedef enum logic [3:0] {
    IDLE,
    LO_ISSUE,
    LO_ARM,
    LO_WAIT,
    HI_ISSUE,
    HI_ARM,
    HI_WAIT,
    DONE
`ifdef SPI_WORD_PREFETCH_EN
    ,
    PF_LO_ISSUE,
    PF_LO_ARM,
    PF_LO_WAIT,
    PF_HI_ISSUE,
    PF_HI_ARM,
    PF_HI_WAIT
`endif
  } state_t;

  state_t               state, state_nxt;
  logic [ADDR_BITS-1:0] addr_q;
  logic [15:0]          wdata_q;
  logic                 op_wr;
  logic [7:0]           asm_lo;
  logic                 accept;
  logic                 pf_hit;

`ifdef SPI_WORD_PREFETCH_EN
  logic                 pf_valid;
  logic [ADDR_BITS-1:0] pf_addr;
  logic [15:0]          pf_data;
  logic [7:0]           pf_lo;

  // Writes never hit: they must reach the RAM and kill the buffer.
  assign pf_hit = pf_valid && !req_write && (req_addr == pf_addr);
`else
  assign pf_hit = 1'b0;
`endif

  // Outputs decoded from state are qualified by rst_n so nothing is
  // presented to the controller or the CPU during a reset cycle.
  assign ready     = rst_n && (state == IDLE);
  assign rsp_valid = rst_n && (state == DONE);
  assign accept    = ready && (req_read || req_write);

  always_comb begin
    ram_start_write = 1'b0;
    ram_start_read  = 1'b0;
    if (rst_n) begin
      if (state == LO_ISSUE || state == HI_ISSUE) begin
        ram_start_write = op_wr;
        ram_start_read  = !op_wr;
      end
`ifdef SPI_WORD_PREFETCH_EN
      if (state == PF_LO_ISSUE || state == PF_HI_ISSUE)
        ram_start_read = 1'b1;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept) state_nxt = pf_hit ? DONE : LO_ISSUE;
      LO_ISSUE: state_nxt = LO_ARM;
      // Controller raises busy only the cycle after start; skip one cycle
      // so a stale busy=0 is not mistaken for completion.
      LO_ARM:   state_nxt = LO_WAIT;
      LO_WAIT:  if (!ram_busy) state_nxt = HI_ISSUE;
      HI_ISSUE: state_nxt = HI_ARM;
      HI_ARM:   state_nxt = HI_WAIT;
      HI_WAIT:  if (!ram_busy) state_nxt = DONE;
`ifdef SPI_WORD_PREFETCH_EN
      DONE:        state_nxt = op_wr ? IDLE : PF_LO_ISSUE;
      PF_LO_ISSUE: state_nxt = PF_LO_ARM;
      PF_LO_ARM:   state_nxt = PF_LO_WAIT;
      PF_LO_WAIT:  if (!ram_busy) state_nxt = PF_HI_ISSUE;
      PF_HI_ISSUE: state_nxt = PF_HI_ARM;
      PF_HI_ARM:   state_nxt = PF_HI_WAIT;
      PF_HI_WAIT:  if (!ram_busy) state_nxt = IDLE;
`else
      DONE:     state_nxt = IDLE;
`endif
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      op_wr     <= 1'b0;
      asm_lo    <= '0;
      rsp_rdata <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
`ifdef SPI_WORD_PREFETCH_EN
      pf_valid  <= 1'b0;
      pf_addr   <= '0;
      pf_data   <= '0;
      pf_lo     <= '0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (accept) begin
          addr_q    <= req_addr;
          wdata_q   <= req_wdata;
          op_wr     <= req_write;   // write wins when both are asserted
          ram_addr  <= req_addr;
          ram_wdata <= req_wdata[7:0];
`ifdef SPI_WORD_PREFETCH_EN
          if (req_write) pf_valid <= 1'b0;
          if (pf_hit)    rsp_rdata <= pf_data;
`endif
        end
        LO_WAIT: if (!ram_busy) begin
          if (!op_wr) asm_lo <= ram_rdata;
          ram_addr  <= addr_q + ADDR_BITS'(1);
          ram_wdata <= wdata_q[15:8];
        end
        // Response word becomes visible together with rsp_valid.
        HI_WAIT: if (!ram_busy && !op_wr) rsp_rdata <= {ram_rdata, asm_lo};
`ifdef SPI_WORD_PREFETCH_EN
        DONE: if (!op_wr) begin
          ram_addr <= addr_q + ADDR_BITS'(2);
          pf_addr  <= addr_q + ADDR_BITS'(2);
          pf_valid <= 1'b0;
        end
        PF_LO_WAIT: if (!ram_busy) begin
          pf_lo    <= ram_rdata;
          ram_addr <= pf_addr + ADDR_BITS'(1);
        end
        PF_HI_WAIT: if (!ram_busy) begin
          pf_data  <= {ram_rdata, pf_lo};
          pf_valid <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_word_port.sv
// Directed bench for spi_word_port with a behavioural byte RAM controller.
module tb_spi_word_port;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] req_addr = '0;
  logic        req_read = 1'b0;
  logic        req_write = 1'b0;
  logic [15:0] req_wdata = '0;
  logic        ready, rsp_valid;
  logic [15:0] rsp_rdata;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_start_read, ram_start_write;
  logic [7:0]  ram_rdata = '0;
  logic        ram_busy = 1'b0;

  int errors = 0;
  int checks = 0;
  int busy_len = 5;

  logic [7:0]  mem [0:65535];
  logic [15:0] log_addr [$];
  logic [7:0]  log_data [$];
  logic        log_wr [$];

  spi_word_port #(.ADDR_BITS(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_addr(req_addr), .req_read(req_read), .req_write(req_write),
    .req_wdata(req_wdata), .ready(ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_start_read(ram_start_read), .ram_start_write(ram_start_write),
    .ram_rdata(ram_rdata), .ram_busy(ram_busy)
  );

  always #5 clk = ~clk;

  // Controller model: busy from the cycle after start for busy_len cycles;
  // read data appears as busy falls.
  logic [15:0] m_a;
  logic [7:0]  m_d;
  logic        m_wr;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && (ram_start_read || ram_start_write)) begin
        m_a = ram_addr; m_d = ram_wdata; m_wr = ram_start_write;
        @(posedge clk); #1 ram_busy = 1'b1;
        repeat (busy_len) @(posedge clk);
        #1;
        ram_busy = 1'b0;
        if (m_wr) mem[m_a] = m_d;
        else      ram_rdata = mem[m_a];
      end
    end
  end

  // Start-pulse monitor: logs every pulse and checks handshake rules.
  initial begin
    forever begin
      @(negedge clk);
      if (ram_start_read || ram_start_write) begin
        log_addr.push_back(ram_addr);
        log_data.push_back(ram_wdata);
        log_wr.push_back(ram_start_write);
        checks++;
        if (ram_start_read && ram_start_write) begin
          errors++; $display("FAIL start_exclusive: both starts high, required one");
        end
        checks++;
        if (ram_busy !== 1'b0) begin
          errors++; $display("FAIL start_outstanding: busy=%b at start, required 0", ram_busy);
        end
      end
    end
  end

  // Stimulus driver only; callers check results. lat=-1 on timeout.
  task automatic do_req(input logic [15:0] a, input logic rd, input logic wr,
                        input logic [15:0] wd, output int lat);
    int w;
    lat = -1;
    @(posedge clk); #1;
    w = 0;
    while (ready !== 1'b1 && w < 200) begin @(posedge clk); #1; w++; end
    log_addr.delete(); log_data.delete(); log_wr.delete();
    req_addr = a; req_read = rd; req_write = wr; req_wdata = wd;
    @(posedge clk); #1;
    req_read = 1'b0; req_write = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin lat = k; break; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({ready, rsp_valid, ram_start_read, ram_start_write} !== 4'b0000) begin
        errors++; $display("FAIL reset_outputs: rdy/vld/sr/sw=%b required 0000",
                           {ready, rsp_valid, ram_start_read, ram_start_write});
      end
    end
    checks++;
    if (rsp_rdata !== 16'h0000 || ram_addr !== 16'h0000 || ram_wdata !== 8'h00) begin
      errors++; $display("FAIL reset_regs: rdata=%h addr=%h wdata=%h required 0", rsp_rdata, ram_addr, ram_wdata);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: ready=%b required 1", ready);
    end
  endtask

  task automatic test_read;
    int lat;
    mem[16'h1234] = 8'hCD; mem[16'h1235] = 8'hAB;
    do_req(16'h1234, 1'b1, 1'b0, 16'h0, lat);
    checks++;
    if (lat != 15) begin errors++; $display("FAIL read_latency: got %0d required 15", lat); end
    checks++;
    if (rsp_rdata !== 16'hABCD) begin errors++; $display("FAIL read_data: got %h required abcd", rsp_rdata); end
    checks++;
    if (log_addr.size() != 2 || log_addr[0] !== 16'h1234 || log_addr[1] !== 16'h1235 || log_wr[0] || log_wr[1]) begin
      errors++; $display("FAIL read_starts: n=%0d required 2 reads at 1234/1235", log_addr.size());
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL read_pulse: rsp_valid=%b required 0", rsp_valid); end
`ifndef SPI_WORD_PREFETCH_EN
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL read_ready: ready=%b required 1", ready); end
`endif
  endtask

  task automatic test_write;
    int lat;
    do_req(16'h0010, 1'b0, 1'b1, 16'hBEEF, lat);
    checks++;
    if (lat != 15) begin errors++; $display("FAIL write_latency: got %0d required 15", lat); end
    checks++;
    if (log_addr.size() != 2 || log_addr[0] !== 16'h0010 || log_data[0] !== 8'hEF || !log_wr[0]
        || log_addr[1] !== 16'h0011 || log_data[1] !== 8'hBE || !log_wr[1]) begin
      errors++; $display("FAIL write_starts: n=%0d required writes 0010/ef 0011/be", log_addr.size());
    end
    checks++;
    if (rsp_rdata !== 16'hABCD) begin errors++; $display("FAIL write_rdata_hold: got %h required abcd", rsp_rdata); end
    checks++;
    if (mem[16'h0010] !== 8'hEF || mem[16'h0011] !== 8'hBE) begin
      errors++; $display("FAIL write_mem: got %h%h required beef", mem[16'h0011], mem[16'h0010]);
    end
  endtask

  task automatic test_wrap_and_priority;
    int lat;
    mem[16'hFFFF] = 8'h11; mem[16'h0000] = 8'h22;
    do_req(16'hFFFF, 1'b1, 1'b0, 16'h0, lat);
    checks++;
    if (lat != 15 || rsp_rdata !== 16'h2211) begin
      errors++; $display("FAIL wrap_read: lat=%0d data=%h required 15/2211", lat, rsp_rdata);
    end
    checks++;
    if (log_addr.size() != 2 || log_addr[1] !== 16'h0000) begin
      errors++; $display("FAIL wrap_addr: second addr=%h required 0000", log_addr.size() > 1 ? log_addr[1] : 16'hxxxx);
    end
    do_req(16'h0200, 1'b1, 1'b1, 16'h5566, lat);
    checks++;
    if (log_addr.size() != 2 || !log_wr[0] || !log_wr[1]) begin
      errors++; $display("FAIL both_write_wins: n=%0d required 2 writes", log_addr.size());
    end
    checks++;
    if (rsp_rdata !== 16'h2211) begin errors++; $display("FAIL both_rdata_hold: got %h required 2211", rsp_rdata); end
    do_req(16'h0200, 1'b1, 1'b0, 16'h0, lat);
    checks++;
    if (rsp_rdata !== 16'h5566) begin errors++; $display("FAIL both_readback: got %h required 5566", rsp_rdata); end
  endtask

  task automatic test_prefetch;
    int lat;
    mem[16'h0100] = 8'h01; mem[16'h0101] = 8'h02;
    mem[16'h0102] = 8'h03; mem[16'h0103] = 8'h04;
    mem[16'h0104] = 8'h05; mem[16'h0105] = 8'h06;
    do_req(16'h0100, 1'b1, 1'b0, 16'h0, lat);
    checks++;
    if (lat != 15 || rsp_rdata !== 16'h0201) begin
      errors++; $display("FAIL pf_first: lat=%0d data=%h required 15/0201", lat, rsp_rdata);
    end
    do_req(16'h0102, 1'b1, 1'b0, 16'h0, lat);
`ifdef SPI_WORD_PREFETCH_EN
    checks++;
    if (lat != 1) begin errors++; $display("FAIL pf_hit_latency: got %0d required 1", lat); end
`else
    checks++;
    if (lat != 15) begin errors++; $display("FAIL nopf_latency: got %0d required 15", lat); end
`endif
    checks++;
    if (rsp_rdata !== 16'h0403) begin errors++; $display("FAIL pf_second_data: got %h required 0403", rsp_rdata); end
    do_req(16'h0104, 1'b0, 1'b1, 16'h7788, lat);
    do_req(16'h0104, 1'b1, 1'b0, 16'h0, lat);
    checks++;
    if (lat != 15 || rsp_rdata !== 16'h7788) begin
      errors++; $display("FAIL pf_write_inval: lat=%0d data=%h required 15/7788", lat, rsp_rdata);
    end
  endtask

  task automatic test_back_to_back;
    int w;
    int n;
    @(posedge clk); #1;
    w = 0;
    while (ready !== 1'b1 && w < 200) begin @(posedge clk); #1; w++; end
    log_addr.delete(); log_data.delete(); log_wr.delete();
    req_addr = 16'h1234; req_read = 1'b1;
    @(posedge clk); #1;
    req_addr = 16'h3000;          // held while busy: must be ignored
    repeat (8) @(posedge clk);
    #1 req_read = 1'b0;
    n = -1;
    for (int k = 9; k <= 200; k++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin n = k; break; end
    end
    checks++;
    if (n != 15 || rsp_rdata !== 16'hABCD) begin
      errors++; $display("FAIL b2b_result: lat=%0d data=%h required 15/abcd", n, rsp_rdata);
    end
    checks++;
    if (log_addr.size() != 2 || log_addr[0] !== 16'h1234) begin
      errors++; $display("FAIL b2b_starts: n=%0d required 2", log_addr.size());
    end
  endtask

  task automatic test_mid_reset;
    int n;
    @(posedge clk); #1;
    n = 0;
    while (ready !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    req_addr = 16'h1234; req_read = 1'b1;
    @(posedge clk); #1 req_read = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({ready, rsp_valid, ram_start_read, ram_start_write} !== 4'b0000) begin
        errors++; $display("FAIL midrst_outputs: rdy/vld/sr/sw=%b required 0000",
                           {ready, rsp_valid, ram_start_read, ram_start_write});
      end
    end
    @(posedge clk); #1 rst_n = 1'b1;
    log_addr.delete(); log_data.delete(); log_wr.delete();
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || rsp_rdata !== 16'h0000) begin
      errors++; $display("FAIL midrst_release: ready=%b rdata=%h required 1/0000", ready, rsp_rdata);
    end
    n = 0;
    repeat (20) begin @(negedge clk); if (rsp_valid) n++; end
    checks++;
    if (n != 0 || log_addr.size() != 0) begin
      errors++; $display("FAIL midrst_quiet: pulses=%0d starts=%0d required 0/0", n, log_addr.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    test_reset();
    test_read();
    test_write();
    test_wrap_and_priority();
    test_prefetch();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
